// File: rtl/microcode_pkg.sv
// Shared definitions for the microcode loader slice.
// Holds the default geometry of the writable control store (WCS), the frame
// start byte, the loader FSM state type and the control word type.
package microcode_pkg;

  localparam int unsigned DEF_ADR_W  = 4;
  localparam int unsigned DEF_WORD_W = 16;
  localparam logic [7:0]  DEF_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CTL,
    DATA,
    WRITE,
    CSUM
  } loader_state_t;

  typedef logic [DEF_WORD_W-1:0] ctrl_word_t;

endpackage

// File: rtl/microcode_word_assembler.sv
// Packs accepted bytes, least-significant byte first, into one control word.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   clear       - frame start; restarts the byte count and empties the word
//   byte_valid  - byte_in is accepted this cycle
//   byte_in     - incoming byte
//   word        - assembled word (stable until the next accepted byte)
//   word_done   - the byte accepted this cycle completes the word
module microcode_word_assembler
  import microcode_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  localparam int unsigned NB = WORD_W / 8;
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

  logic [CW-1:0] cnt;

  assign word_done = byte_valid && (cnt == CW'(NB - 1));

  // New byte enters at the top and older bytes slide down, so after NB bytes
  // the first one received sits in the least-significant position.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt  <= '0;
      word <= '0;
    end else if (byte_valid) begin
      cnt  <= word_done ? '0 : cnt + CW'(1);
      word <= (word >> 8) | (WORD_W'(byte_in) << (WORD_W - 8));
    end
  end

endmodule

// File: rtl/microcode_loader.sv
// Writer side of the microprogram writable control store (WCS).
// Receives framed bytes (HEADER, CTL, data words, CSUM) over valid/ready and
// writes each completed control word to the WCS; keeps the CPU held in reset
// until a frame with a good checksum has been loaded.
// Ports:
//   clk, reset         - clock and synchronous active-high reset
//   in_valid, in_data  - byte stream input
//   in_ready           - byte accepted when in_valid & in_ready
//   wcs_we             - one-cycle write strobe per word
//   wcs_adr, wcs_wd    - WCS write address and data
//   hold_cpu           - keep datapath and sequencer in reset
//   done               - one-cycle pulse at the end of every frame
//   error              - sticky checksum-fail flag, cleared at next frame start
module microcode_loader
  import microcode_pkg::*;
#(
  parameter int unsigned ADR_W  = DEF_ADR_W,
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter logic [7:0]  HEADER = DEF_HEADER
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wcs_we,
  output logic [ADR_W-1:0]  wcs_adr,
  output logic [WORD_W-1:0] wcs_wd,
  output logic              hold_cpu,
  output logic              done,
  output logic              error
);

  loader_state_t state, state_nx;

  logic             accept;
  logic             frame_start;
  logic             word_done;
  logic [ADR_W-1:0] adr;
  logic [3:0]       rem;
  logic [7:0]       csum;
  logic             hold_q;
  logic             err_q;
  logic             done_q;

  assign accept      = in_valid && in_ready;
  assign frame_start = (state == IDLE) && accept && (in_data == HEADER);

  microcode_word_assembler #(
    .WORD_W (WORD_W)
  ) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (frame_start),
    .byte_valid (accept && (state == DATA)),
    .byte_in    (in_data),
    .word       (wcs_wd),
    .word_done  (word_done)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (frame_start) state_nx = CTL;
      CTL:     if (accept)      state_nx = DATA;
      DATA:    if (word_done)   state_nx = WRITE;
      WRITE:   state_nx = (rem == 4'd0) ? CSUM : DATA;
      CSUM:    if (accept)      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state != WRITE);
    wcs_we   = (state == WRITE);
  end

  // Address/count counters, checksum accumulator and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      adr    <= '0;
      rem    <= '0;
      csum   <= '0;
      hold_q <= 1'b1;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            csum   <= '0;
            hold_q <= 1'b1;
            err_q  <= 1'b0;
          end
        end
        CTL: begin
          if (accept) begin
            adr  <= ADR_W'(in_data[7:4]);
            rem  <= in_data[3:0];
            csum <= csum ^ in_data;
          end
        end
        DATA: begin
          if (accept) csum <= csum ^ in_data;
        end
        WRITE: begin
          adr <= adr + ADR_W'(1);
          rem <= rem - 4'd1;
        end
        CSUM: begin
          if (accept) begin
            done_q <= 1'b1;
            if (in_data == csum) begin
              hold_q <= 1'b0;
              err_q  <= 1'b0;
            end else begin
              err_q  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign wcs_adr  = adr;
  assign hold_cpu = hold_q;
  assign done     = done_q;
  assign error    = err_q;

endmodule
